// File: rtl/nibble_pkg.sv
// ============================================================================
//  Module   : nibble_pkg
//  Purpose  : Constants, FSM encoding and helpers shared by the nibble stages.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package nibble_pkg;

  localparam int NIBBLE_W     = 4;
  // Must track the pipeline depth of nibble_mayor_2in.
  localparam int COMP_LATENCY = 4;

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_ACUM = 1'b1;

  typedef enum logic {
    S_IDLE = ST_IDLE,
    S_ACUM = ST_ACUM
  } acc_state_e;

  function automatic int idx_width(input int frame_len);
    return (frame_len > 1) ? $clog2(frame_len) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/nibble_mayor_acumulador_if.sv
// ============================================================================
//  Module   : nibble_mayor_acumulador_if
//  Purpose  : Sample input and buffered frame-result output of the accumulator.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface nibble_mayor_acumulador_if
  import nibble_pkg::*;
#(
  parameter int IDX_W = 2
);

  logic                acc_in_valid;
  logic [NIBBLE_W-1:0] acc_nibble;
  logic                acc_out_valid;
  logic                acc_out_ready;
  logic [NIBBLE_W-1:0] acc_out_max;
  logic [IDX_W-1:0]    acc_out_idx;
  logic                acc_overflow;

  modport master (
    output acc_in_valid,
    output acc_nibble,
    output acc_out_ready,
    input  acc_out_valid,
    input  acc_out_max,
    input  acc_out_idx,
    input  acc_overflow
  );

  modport slave (
    input  acc_in_valid,
    input  acc_nibble,
    input  acc_out_ready,
    output acc_out_valid,
    output acc_out_max,
    output acc_out_idx,
    output acc_overflow
  );

endinterface

`default_nettype wire

// File: rtl/nibble_fifo2.sv
// ============================================================================
//  Module   : nibble_fifo2
//  Purpose  : Two-entry FIFO; the head register holds its value once drained.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module nibble_fifo2 #(
  parameter int WIDTH = 6
) (
  input  logic             CLK,
  input  logic             RESET_L,
  input  logic             clear,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] head_q, head_d;
  logic [WIDTH-1:0] tail_q, tail_d;
  logic [1:0]       count_q, count_d;
  logic             do_pop;
  logic             do_push;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    // A pop on an empty FIFO is void; a full FIFO only takes a push it can pop for.
    do_pop  = pop && (count_q != 2'd0);
    do_push = push && ((count_q != 2'd2) || do_pop);

    if (clear) begin
      count_d = 2'd0;
    end else begin
      case ({do_push, do_pop})
        2'b11: begin
          if (count_q == 2'd1) begin
            head_d = din;
          end else begin
            head_d = tail_q;
            tail_d = din;
          end
        end
        2'b10: begin
          if (count_q == 2'd0) head_d = din;
          else                 tail_d = din;
          count_d = count_q + 2'd1;
        end
        2'b01: begin
          if (count_q == 2'd2) head_d = tail_q;
          count_d = count_q - 2'd1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RESET_L) begin
    if (!RESET_L) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= 2'd0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign dout  = head_q;
  assign full  = (count_q == 2'd2);
  assign empty = (count_q == 2'd0);

endmodule

`default_nettype wire

// File: rtl/nibble_mayor_acumulador.sv
// ============================================================================
//  Module   : nibble_mayor_acumulador
//  Purpose  : Per-frame maximum nibble and first-occurrence index of the
//             comparator winner stream, buffered behind valid/ready.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module nibble_mayor_acumulador
  import nibble_pkg::*;
#(
  parameter int LATENCY   = COMP_LATENCY,
  parameter int FRAME_LEN = 4
) (
  input  logic                        CLK,
  input  logic                        RESET_L,
  input  logic                        acc_clear,
  nibble_mayor_acumulador_if.slave    bus
);

  localparam int               IDX_W    = idx_width(FRAME_LEN);
  localparam int               ENTRY_W  = NIBBLE_W + IDX_W;
  localparam logic [IDX_W-1:0] CNT_LAST = IDX_W'(FRAME_LEN - 1);

  logic [LATENCY-1:0]  dly_q, dly_d, dly_shift;
  logic                smp;
  acc_state_e          state_q, state_d;
  logic [IDX_W-1:0]    cnt_q, cnt_d;
  logic [NIBBLE_W-1:0] max_q, max_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                overflow_q, overflow_d;

  logic                push;
  logic                pop;
  logic                full;
  logic                empty;
  logic [ENTRY_W-1:0]  push_data;
  logic [ENTRY_W-1:0]  head;

  // acc_in_valid travels alongside the pair through the comparator pipeline.
  generate
    if (LATENCY == 1) begin : g_dly_single
      assign dly_shift = bus.acc_in_valid;
    end else begin : g_dly_multi
      assign dly_shift = {dly_q[LATENCY-2:0], bus.acc_in_valid};
    end
  endgenerate

  assign smp = dly_q[LATENCY-1];
  assign pop = !empty && bus.acc_out_ready;

  always_comb begin
    dly_d      = dly_shift;
    state_d    = state_q;
    cnt_d      = cnt_q;
    max_d      = max_q;
    idx_d      = idx_q;
    overflow_d = overflow_q;
    push       = 1'b0;

    if (acc_clear) begin
      dly_d      = '0;
      state_d    = S_IDLE;
      cnt_d      = '0;
      overflow_d = 1'b0;
    end else begin
      if (smp) begin
        case (state_q)
          S_IDLE: begin
            max_d   = bus.acc_nibble;
            idx_d   = '0;
            cnt_d   = IDX_W'(1);
            state_d = S_ACUM;
          end
          S_ACUM: begin
            // Strict compare so ties keep the earliest index.
            if (bus.acc_nibble > max_q) begin
              max_d = bus.acc_nibble;
              idx_d = cnt_q;
            end
            if (cnt_q == CNT_LAST) begin
              push    = 1'b1;
              cnt_d   = '0;
              state_d = S_IDLE;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
          default: state_d = S_IDLE;
        endcase
      end
      if (push && full && !pop) overflow_d = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RESET_L) begin
    if (!RESET_L) begin
      dly_q      <= '0;
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      max_q      <= '0;
      idx_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      dly_q      <= dly_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      max_q      <= max_d;
      idx_q      <= idx_d;
      overflow_q <= overflow_d;
    end
  end

  // The pushed entry already includes the closing sample.
  assign push_data = {max_d, idx_d};

  nibble_fifo2 #(
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .CLK     (CLK),
    .RESET_L (RESET_L),
    .clear   (acc_clear),
    .push    (push),
    .pop     (pop),
    .din     (push_data),
    .dout    (head),
    .full    (full),
    .empty   (empty)
  );

  assign bus.acc_out_valid = !empty;
  assign bus.acc_out_max   = head[ENTRY_W-1:IDX_W];
  assign bus.acc_out_idx   = head[IDX_W-1:0];
  assign bus.acc_overflow  = overflow_q;

endmodule

`default_nettype wire
